ppu_bg_fetch: RTL

//  Background-layer scanline fetcher. On each line_start it streams the 320 pixels of one line.
//  Per pixel it reads map RAM, then tile RAM, then palette RAM, and outputs a 32-bit colour.

---
 rtl/ppu_bg_fetch_pkg.sv | 37 +++
 rtl/ppu_bg_fetch_if.sv | 45 ++++
 rtl/ppu_bg_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ppu_bg_fetch_pkg.sv
// rtl/ppu_bg_fetch_pkg.sv - shared widths, map-entry layout, stage record and map address helper
package ppu_bg_fetch_pkg;

  localparam int SCREEN_W       = 320;
  localparam int MAP_ADDR_W     = 11;
  localparam int MAP_DATA_W     = 16;
  localparam int TILE_ADDR_W    = 15;
  localparam int TILE_DATA_W    = 8;
  localparam int PAL_ADDR_W     = 8;
  localparam int PAL_DATA_W     = 32;
  localparam int BG_MAP_W_TILES = 64;
  localparam int BG_MAP_H_TILES = 32;

  localparam logic [8:0] BG_LAST_X = 9'(SCREEN_W - 1);

  typedef struct packed {
    logic [4:0] rsvd;
    logic       vflip;
    logic       hflip;
    logic [8:0] tile;
  } bg_map_entry_t;

  // One pixel travelling down the fetch pipeline
  typedef struct packed {
    logic       valid;
    logic       en;
    logic [8:0] x;
    logic [2:0] row;
    logic [2:0] col;
    logic       opaque;
  } bg_stage_t;

  function automatic logic [MAP_ADDR_W-1:0] bg_map_addr(input logic [8:0] bx, input logic [7:0] by);
    return {by[7:3], bx[8:3]};
  endfunction

endpackage

// File: rtl/ppu_bg_fetch_if.sv
// rtl/ppu_bg_fetch_if.sv - line control, RAM read ports and pixel stream of the BG fetcher
interface ppu_bg_fetch_if;
  import ppu_bg_fetch_pkg::*;

  logic                   line_start;
  logic [7:0]             line_y;
  logic [8:0]             scroll_x;
  logic [7:0]             scroll_y;
  logic                   bg_enable;

  logic                   map_re;
  logic [MAP_ADDR_W-1:0]  map_addr;
  logic [MAP_DATA_W-1:0]  map_rdata;
  logic                   tile_re;
  logic [TILE_ADDR_W-1:0] tile_addr;
  logic [TILE_DATA_W-1:0] tile_rdata;
  logic                   pal_re;
  logic [PAL_ADDR_W-1:0]  pal_addr;
  logic [PAL_DATA_W-1:0]  pal_rdata;

  logic                   px_valid;
  logic                   px_ready;
  logic [8:0]             px_x;
  logic [PAL_DATA_W-1:0]  px_color;
  logic                   px_opaque;

  logic                   busy;
  logic                   line_done;
  logic                   overrun;

  modport master (
    input  line_start, line_y, scroll_x, scroll_y, bg_enable,
    input  map_rdata, tile_rdata, pal_rdata, px_ready,
    output map_re, map_addr, tile_re, tile_addr, pal_re, pal_addr,
    output px_valid, px_x, px_color, px_opaque, busy, line_done, overrun
  );

  modport slave (
    output line_start, line_y, scroll_x, scroll_y, bg_enable,
    output map_rdata, tile_rdata, pal_rdata, px_ready,
    input  map_re, map_addr, tile_re, tile_addr, pal_re, pal_addr,
    input  px_valid, px_x, px_color, px_opaque, busy, line_done, overrun
  );

endinterface

// File: rtl/ppu_bg_fetch.sv
// rtl/ppu_bg_fetch.sv - background scanline fetcher: map -> tile -> palette -> 320-pixel stream
// Build option PPU_BG_FLIP_EN: honour the hflip/vflip bits of each map entry.
module ppu_bg_fetch
  import ppu_bg_fetch_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ppu_bg_fetch_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [8:0]            r_x;
  logic [8:0]            r_sx;
  logic [7:0]            r_by;
  logic                  r_en;
  bg_stage_t             r_st [1:3];
  logic                  r_px_valid;
  logic [8:0]            r_px_x;
  logic [PAL_DATA_W-1:0] r_px_color;
  logic                  r_px_opaque;

  logic                  w_adv;
  logic                  w_run;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_start;
  logic [8:0]            w_bx;
  bg_map_entry_t         w_entry;
  logic                  w_hflip;
  logic                  w_vflip;
  logic                  w_tile_act;
  logic                  w_pal_act;
  logic                  w_out_opaque;
  bg_stage_t             w_s1_d;
  bg_stage_t             w_s3_d;
  logic                  w_unused;

  assign w_adv   = !r_px_valid || bus.px_ready;
  assign w_run   = (r_state == ST_RUN);
  assign w_busy  = (r_state != ST_IDLE);
  assign w_done  = (r_state == ST_DRAIN) && r_px_valid && bus.px_ready && (r_px_x == BG_LAST_X);
  // A new line may start in the very cycle the previous line's last pixel leaves
  assign w_start = bus.line_start && ((r_state == ST_IDLE) || w_done);
  assign w_bx    = r_x + r_sx;
  assign w_entry = bg_map_entry_t'(bus.map_rdata);

`ifdef PPU_BG_FLIP_EN
  assign w_hflip = w_entry.hflip;
  assign w_vflip = w_entry.vflip;
`else
  assign w_hflip = 1'b0;
  assign w_vflip = 1'b0;
`endif

  always_comb begin
    w_s1_d        = '0;
    w_s1_d.valid  = w_run;
    w_s1_d.en     = r_en;
    w_s1_d.x      = r_x;
    w_s1_d.row    = r_by[2:0];
    w_s1_d.col    = w_bx[2:0];
    w_s3_d        = r_st[2];
    w_s3_d.opaque = r_st[2].en && (bus.tile_rdata != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_sx    <= '0;
      r_by    <= '0;
      r_en    <= 1'b0;
    end else if (w_start) begin
      r_state <= ST_RUN;
      r_x     <= '0;
      r_sx    <= bus.scroll_x;
      r_by    <= bus.line_y + bus.scroll_y;
      r_en    <= bus.bg_enable;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_adv) begin
            if (r_x == BG_LAST_X) begin
              r_state <= ST_DRAIN;
              r_x     <= '0;
            end else begin
              r_x <= r_x + 9'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Everything moves together on adv, so each RAM still holds the word its stage needs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 3; i++) r_st[i] <= '0;
      r_px_valid  <= 1'b0;
      r_px_x      <= '0;
      r_px_color  <= '0;
      r_px_opaque <= 1'b0;
    end else if (w_adv) begin
      r_st[1]     <= w_s1_d;
      r_st[2]     <= r_st[1];
      r_st[3]     <= w_s3_d;
      r_px_valid  <= r_st[3].valid;
      r_px_x      <= r_st[3].x;
      r_px_opaque <= w_out_opaque;
      r_px_color  <= w_out_opaque ? bus.pal_rdata : '0;
    end
  end

  assign w_out_opaque = r_st[3].valid && r_st[3].opaque;
  assign w_tile_act   = r_st[1].valid && r_st[1].en;
  assign w_pal_act    = r_st[2].valid && r_st[2].en;

  assign bus.map_re    = w_run && r_en && w_adv;
  assign bus.map_addr  = w_run ? bg_map_addr(w_bx, r_by) : '0;
  assign bus.tile_re   = w_tile_act && w_adv;
  assign bus.tile_addr = w_tile_act ? {w_entry.tile, r_st[1].row ^ {3{w_vflip}}, r_st[1].col ^ {3{w_hflip}}} : '0;
  assign bus.pal_re    = w_pal_act && w_adv;
  assign bus.pal_addr  = w_pal_act ? bus.tile_rdata : '0;

  assign bus.px_valid  = r_px_valid;
  assign bus.px_x      = r_px_x;
  assign bus.px_color  = r_px_color;
  assign bus.px_opaque = r_px_opaque;
  assign bus.busy      = w_busy;
  assign bus.line_done = w_done;
  assign bus.overrun   = bus.line_start && w_busy && !w_start;

  assign w_unused = ^{w_entry.rsvd, w_entry.hflip, w_entry.vflip,
                      r_st[3].en, r_st[3].row, r_st[3].col};

endmodule
